// File: rtl/fdd_ready_ctrl.sv
// fdd_ready_ctrl: per-drive media registration, timed spindle FSMs and registered drive-select status.
// Define FDD_DISKCHANGE_EN to build the per-drive disk-change latches behind DSKCHGn.
module fdd_ready_ctrl #(
  parameter int DRIVES   = 4,
  parameter int TICK_DIV = 2147727,
  parameter int DELAY    = 3,
  parameter int TIMEOUT  = 30
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        USEL,
  input  logic [DRIVES-1:0] motor_run,
  input  logic [DRIVES-1:0] img_mounted,
  input  logic              img_readonly,
  input  logic [63:0]       img_size,
  input  logic              dskchg_clr,
  output logic              READYn,
  output logic              sides,
  output logic              WPROTn,
  output logic              DSKCHGn,
  output logic [DRIVES-1:0] spinning
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (DELAY > TIMEOUT) ? DELAY : TIMEOUT;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [63:0]   SIZE_DS      = 64'd737280;
  localparam logic [63:0]   SIZE_SS      = 64'd368640;
  localparam logic [PW-1:0] PRE_LAST     = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DELAY_LAST   = CW'(DELAY - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_OFF, S_SPINUP, S_RUN, S_SPINDOWN} spin_t;

  logic [PW-1:0]     pre_cnt;
  logic              tick;
  logic [DRIVES-1:0] mnt_q;
  logic [DRIVES-1:0] mnt_rise;
  logic [DRIVES-1:0] present;
  logic [DRIVES-1:0] side_r;
  logic [DRIVES-1:0] wprot;
  logic [DRIVES-1:0] chg;
  logic [DRIVES-1:0] ready;
  logic [DRIVES-1:0] sel_oh;
  logic              is_ds;
  logic              is_ss;
  logic              sel_ready;
  logic              sel_sides;
  logic              sel_wprot;
  logic              sel_chg;

  spin_t             state    [DRIVES];
  spin_t             state_nx [DRIVES];
  logic [CW-1:0]     cnt      [DRIVES];
  logic [CW-1:0]     cnt_nx   [DRIVES];

  // Shared prescaler: free-running, never disturbed by motor events.
  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign mnt_rise = img_mounted & ~mnt_q;
  assign is_ds    = (img_size == SIZE_DS);
  assign is_ss    = (img_size == SIZE_SS);

  always_comb begin
    sel_oh = '0;
    for (int unsigned i = 0; i < DRIVES; i++) begin
      sel_oh[i] = (USEL == 2'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mnt_q   <= '0;
      present <= '0;
      side_r  <= '0;
      wprot   <= '1;
    end else begin
      mnt_q <= img_mounted;
      for (int unsigned i = 0; i < DRIVES; i++) begin
        if (mnt_rise[i]) begin
          present[i] <= is_ds | is_ss;
          side_r[i]  <= is_ds;
          wprot[i]   <= (is_ds | is_ss) ? img_readonly : 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DRIVES; i++) begin
        state[i] <= S_OFF;
        cnt[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DRIVES; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
      end
    end
  end

  // The tick that completes the interval also moves the state, so cnt never holds DELAY/TIMEOUT.
  always_comb begin
    for (int unsigned i = 0; i < DRIVES; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      unique case (state[i])
        S_OFF: begin
          if (motor_run[i]) begin
            state_nx[i] = S_SPINUP;
            cnt_nx[i]   = '0;
          end
        end
        S_SPINUP: begin
          if (!motor_run[i]) begin
            state_nx[i] = S_OFF;
            cnt_nx[i]   = '0;
          end else if (tick) begin
            if (cnt[i] == DELAY_LAST) begin
              state_nx[i] = S_RUN;
              cnt_nx[i]   = '0;
            end else begin
              cnt_nx[i] = cnt[i] + CW'(1);
            end
          end
        end
        S_RUN: begin
          if (!motor_run[i]) begin
            state_nx[i] = S_SPINDOWN;
            cnt_nx[i]   = '0;
          end
        end
        S_SPINDOWN: begin
          if (motor_run[i]) begin
            state_nx[i] = S_RUN;
            cnt_nx[i]   = '0;
          end else if (tick) begin
            if (cnt[i] == TIMEOUT_LAST) begin
              state_nx[i] = S_OFF;
              cnt_nx[i]   = '0;
            end else begin
              cnt_nx[i] = cnt[i] + CW'(1);
            end
          end
        end
        default: begin
          state_nx[i] = S_OFF;
          cnt_nx[i]   = '0;
        end
      endcase
      if (mnt_rise[i] && (state[i] == S_RUN || state[i] == S_SPINDOWN)) begin
        state_nx[i] = S_SPINUP;
        cnt_nx[i]   = '0;
      end
    end
  end

  always_comb begin
    ready    = '0;
    spinning = '0;
    for (int unsigned i = 0; i < DRIVES; i++) begin
      ready[i]    = present[i] && (state[i] == S_RUN || state[i] == S_SPINDOWN);
      spinning[i] = (state[i] != S_OFF);
    end
  end

`ifdef FDD_DISKCHANGE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chg <= '0;
    end else begin
      for (int unsigned i = 0; i < DRIVES; i++) begin
        if (mnt_rise[i]) begin
          chg[i] <= 1'b1;
        end else if (dskchg_clr && sel_oh[i]) begin
          chg[i] <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_dskchg_clr;
  assign unused_dskchg_clr = dskchg_clr;
  assign chg = '0;
`endif

  // Defaults describe the virtual empty drive seen for USEL >= DRIVES.
  always_comb begin
    sel_ready = 1'b0;
    sel_sides = 1'b0;
    sel_wprot = 1'b1;
    sel_chg   = 1'b0;
    for (int unsigned i = 0; i < DRIVES; i++) begin
      if (sel_oh[i]) begin
        sel_ready = ready[i];
        sel_sides = side_r[i];
        sel_wprot = wprot[i];
        sel_chg   = chg[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      READYn  <= 1'b1;
      sides   <= 1'b0;
      WPROTn  <= 1'b0;
      DSKCHGn <= 1'b1;
    end else begin
      READYn  <= ~sel_ready;
      sides   <= sel_sides;
      WPROTn  <= ~sel_wprot;
      DSKCHGn <= ~sel_chg;
    end
  end

endmodule

// File: tb/tb_fdd_ready_ctrl.sv
// tb_fdd_ready_ctrl: directed drive scenarios plus random traffic, compared every cycle
// against a behavioural model of media, spindle timing and select outputs.
module tb_fdd_ready_ctrl;

  localparam int DRV  = 3;
  localparam int TDIV = 10;
  localparam int DLY  = 3;
  localparam int TMO  = 4;
`ifdef FDD_DISKCHANGE_EN
  localparam bit CHG_EN = 1'b1;
`else
  localparam bit CHG_EN = 1'b0;
`endif

  logic           clk;
  logic           reset_n;
  logic [1:0]     USEL;
  logic [DRV-1:0] motor_run;
  logic [DRV-1:0] img_mounted;
  logic           img_readonly;
  logic [63:0]    img_size;
  logic           dskchg_clr;
  logic           READYn;
  logic           sides;
  logic           WPROTn;
  logic           DSKCHGn;
  logic [DRV-1:0] spinning;

  fdd_ready_ctrl #(
    .DRIVES   (DRV),
    .TICK_DIV (TDIV),
    .DELAY    (DLY),
    .TIMEOUT  (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .USEL         (USEL),
    .motor_run    (motor_run),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_size     (img_size),
    .dskchg_clr   (dskchg_clr),
    .READYn       (READYn),
    .sides        (sides),
    .WPROTn       (WPROTn),
    .DSKCHGn      (DSKCHGn),
    .spinning     (spinning)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  bit chk_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: elapsed-cycle prescaler, per-drive media and spindle bookkeeping.
  int  m_cyc;
  bit  m_prev  [DRV];
  bit  m_pres  [DRV];
  bit  m_sides [DRV];
  bit  m_wprot [DRV];
  bit  m_chg   [DRV];
  bit  m_turn  [DRV];
  bit  m_fast  [DRV];
  bit  m_coast [DRV];
  int  m_ticks [DRV];
  bit  e_readyn, e_sides, e_wprotn, e_dskchgn;
  bit  m_tick, m_rise;
  int  m_sel;

  task automatic model_reset();
    m_cyc = 0;
    for (int i = 0; i < DRV; i++) begin
      m_prev[i] = 0; m_pres[i] = 0; m_sides[i] = 0; m_wprot[i] = 1; m_chg[i] = 0;
      m_turn[i] = 0; m_fast[i] = 0; m_coast[i] = 0; m_ticks[i] = 0;
    end
    e_readyn = 1; e_sides = 0; e_wprotn = 0; e_dskchgn = 1;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      m_tick = ((m_cyc % TDIV) == TDIV - 1);
      m_cyc++;
      m_sel = int'(USEL);
      if (m_sel < DRV) begin
        e_readyn  = !(m_pres[m_sel] && m_fast[m_sel]);
        e_sides   = m_sides[m_sel];
        e_wprotn  = !m_wprot[m_sel];
        e_dskchgn = !(CHG_EN && m_chg[m_sel]);
      end else begin
        e_readyn = 1; e_sides = 0; e_wprotn = 0; e_dskchgn = 1;
      end
      for (int i = 0; i < DRV; i++) begin
        m_rise = img_mounted[i] && !m_prev[i];
        m_prev[i] = img_mounted[i];
        if (m_rise) begin
          m_chg[i] = 1;
          if (img_size == 64'd737280) begin
            m_pres[i] = 1; m_sides[i] = 1; m_wprot[i] = img_readonly;
          end else if (img_size == 64'd368640) begin
            m_pres[i] = 1; m_sides[i] = 0; m_wprot[i] = img_readonly;
          end else begin
            m_pres[i] = 0; m_sides[i] = 0; m_wprot[i] = 1;
          end
        end else if (dskchg_clr && m_sel == i) begin
          m_chg[i] = 0;
        end
        if (m_rise && m_fast[i]) begin
          m_fast[i] = 0; m_coast[i] = 0; m_ticks[i] = 0;
        end else if (!m_turn[i]) begin
          if (motor_run[i]) begin m_turn[i] = 1; m_ticks[i] = 0; end
        end else if (!m_fast[i]) begin
          if (!motor_run[i]) m_turn[i] = 0;
          else if (m_tick) begin
            m_ticks[i]++;
            if (m_ticks[i] == DLY) begin m_fast[i] = 1; m_coast[i] = 0; end
          end
        end else if (!m_coast[i]) begin
          if (!motor_run[i]) begin m_coast[i] = 1; m_ticks[i] = 0; end
        end else begin
          if (motor_run[i]) m_coast[i] = 0;
          else if (m_tick) begin
            m_ticks[i]++;
            if (m_ticks[i] == TMO) begin m_turn[i] = 0; m_fast[i] = 0; m_coast[i] = 0; end
          end
        end
      end
    end
  end

  logic [DRV-1:0] e_spin;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < DRV; i++) e_spin[i] = m_turn[i];
      check("m_readyn", READYn, e_readyn);
      check("m_sides", sides, e_sides);
      check("m_wprotn", WPROTn, e_wprotn);
      check("m_dskchgn", DSKCHGn, e_dskchgn);
      check("m_spinning", spinning, e_spin);
    end
  end

  int n;
  bit ok;
  int d;

  initial begin
    checks = 0; errors = 0; chk_en = 0;
    reset_n = 1; USEL = 0; motor_run = '0; img_mounted = '0;
    img_readonly = 0; img_size = '0; dskchg_clr = 0;
    #1 reset_n = 0;
    chk_en = 1;
    repeat (2) @(negedge clk);
    check("rst_readyn", READYn, 1);
    check("rst_sides", sides, 0);
    check("rst_wprotn", WPROTn, 0);
    check("rst_dskchgn", DSKCHGn, 1);
    check("rst_spinning", spinning, 0);
    reset_n = 1;

    // Mount double-sided writable media on drive 0, motor off
    img_size = 64'd737280; img_readonly = 0; img_mounted[0] = 1;
    repeat (2) @(negedge clk);
    check("mnt0_sides", sides, 1);
    check("mnt0_wprotn", WPROTn, 1);
    check("mnt0_readyn", READYn, 1);
    check("mnt0_dskchgn", DSKCHGn, 32'(!CHG_EN));
    img_mounted[0] = 0;

    // Spin-up latency
    motor_run[0] = 1;
    @(negedge clk);
    check("spin0_on", spinning[0], 1);
    n = 1;
    while (READYn !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("spinup_lat_22_32", (n >= 22 && n <= 32), 1);

    // Short motor drop coasts in ready state, long drop stops
    motor_run[0] = 0; ok = 1;
    repeat (15) begin @(negedge clk); if (READYn !== 1'b0) ok = 0; end
    motor_run[0] = 1;
    repeat (3) begin @(negedge clk); if (READYn !== 1'b0) ok = 0; end
    check("coast_ready", ok, 1);
    motor_run[0] = 0;
    repeat (45) @(negedge clk);
    check("stop_readyn", READYn, 1);
    check("stop_spin0", spinning[0], 0);

    // Remount drive 1 while running
    USEL = 1; motor_run[1] = 1;
    repeat (40) @(negedge clk);
    img_size = 64'd368640; img_readonly = 1; img_mounted[1] = 1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) img_mounted[1] = 0;
      if (READYn === 1'b0) break;
    end
    check("remount_lat", (n >= 21 && n <= 33 && READYn === 1'b0), 1);
    check("remount_sides", sides, 0);
    check("remount_wprotn", WPROTn, 0);

    // Unknown size never becomes ready; out-of-range select is an empty drive
    USEL = 2; img_size = 64'd12345; img_readonly = 0; img_mounted[2] = 1; motor_run[2] = 1;
    @(negedge clk);
    img_mounted[2] = 0; ok = 1;
    repeat (40) begin @(negedge clk); if (READYn !== 1'b1) ok = 0; end
    check("badsize_notready", ok, 1);
    USEL = 3;
    repeat (2) @(negedge clk);
    check("virt_readyn", READYn, 1);
    check("virt_wprotn", WPROTn, 0);
    check("virt_sides", sides, 0);
    check("virt_dskchgn", DSKCHGn, 1);

    // Disk-change latch: clear, set-beats-clear, clear again
    USEL = 0; dskchg_clr = 1;
    @(negedge clk); dskchg_clr = 0;
    @(negedge clk);
    check("clr_alone", DSKCHGn, 1);
    img_size = 64'd737280; img_mounted[0] = 1; dskchg_clr = 1;
    @(negedge clk); dskchg_clr = 0; img_mounted[0] = 0;
    @(negedge clk);
    check("set_wins", DSKCHGn, 32'(!CHG_EN));
    dskchg_clr = 1;
    @(negedge clk); dskchg_clr = 0;
    @(negedge clk);
    check("clr_again", DSKCHGn, 1);

    // Random traffic against the model, with one asynchronous reset mid-run
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) begin
        #2 reset_n = 0;
        @(negedge clk);
        reset_n = 1;
      end
      if ($urandom_range(0, 59) == 0) begin
        d = int'($urandom_range(0, DRV - 1));
        motor_run[d] = ~motor_run[d];
      end
      img_mounted = '0;
      if ($urandom_range(0, 79) == 0) begin
        d = int'($urandom_range(0, DRV - 1));
        img_mounted[d] = 1;
      end
      case ($urandom_range(0, 3))
        0: img_size = 64'd737280;
        1: img_size = 64'd368640;
        2: img_size = 64'd0;
        default: img_size = {$urandom, $urandom};
      endcase
      img_readonly = 1'($urandom_range(0, 1));
      dskchg_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) USEL = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    chk_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fdd_ready_ctrl.md
# fdd_ready_ctrl

Per-drive media and spindle status block for the MSX floppy subsystem. It sits between the image-mount interface and the FDC drive-status inputs. It replaces the fixed four-drive ready logic with a `DRIVES`-wide generalisation that adds:
- timed motor spin-up and spin-down, driven by a shared tick prescaler;
- registered drive-select outputs;
- an optional disk-change latch.

## Interface
Parameters:
- `DRIVES`, 4: number of drives, 1..4.
- `TICK_DIV`, 2147727: clk cycles per tick (~100 ms at 21.477 MHz).
- `DELAY`, 3: spin-up time in ticks before ready, ≥1.
- `TIMEOUT`, 30: spin-down hold time in ticks after motor off, ≥1.

Ports:
- `clk`  in  1  system clock; the block has one clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `USEL`  in  2  selected drive index.
- `motor_run`  in  DRIVES  motor request per drive.
- `img_mounted`  in  DRIVES  mount strobe per drive; the rising edge registers media.
- `img_readonly`  in  1  readonly flag, sampled on the mount edge.
- `img_size`  in  64  image size in bytes, sampled on the mount edge.
- `dskchg_clr`  in  1  one-cycle pulse; clears the disk-change latch of the selected drive.
- `READYn`  out  1  selected drive not ready.
- `sides`  out  1  selected media is double-sided.
- `WPROTn`  out  1  selected drive not write-protected.
- `DSKCHGn`  out  1  selected drive has had a media change.
- `spinning`  out  DRIVES  spindle state is not OFF, per drive.

## Operation
Prescaler:
- A free-running counter counts 0..TICK_DIV-1.
- `tick` is a one-cycle pulse when the counter wraps.
- The prescaler is shared by all drives.

Media registration, on the rising edge of `img_mounted[i]`:
- `img_size` = 737280: sides=1, wprot=`img_readonly`, present=1.
- `img_size` = 368640: sides=0, wprot=`img_readonly`, present=1.
- Any other size, including 0 (eject): sides=0, wprot=1, present=0.

Spindle FSM, one per drive, with a tick counter sized for max(DELAY, TIMEOUT):
- OFF: when `motor_run[i]`=1, go to SPINUP with count=0.
- SPINUP:
  - Count increments on each `tick`.
  - When count reaches DELAY, go to RUN.
  - If `motor_run[i]`=0, go to OFF.
- RUN:
  - If `motor_run[i]`=0, go to SPINDOWN with count=0.
- SPINDOWN:
  - Count increments on each `tick`.
  - When count reaches TIMEOUT, go to OFF.
  - If `motor_run[i]`=1, go to RUN; no re-spin-up.
- A mount edge on drive i while in RUN or SPINDOWN forces SPINUP with count=0. The new media is not ready until it has spun up.

Drive ready:
- A drive is ready when present=1 and its state is RUN or SPINDOWN.
- SPINDOWN counts as ready, modelling spindle inertia.

Select outputs:
- Any `USEL` ≥ DRIVES selects a virtual empty drive: READYn=1, sides=0, WPROTn=0, DSKCHGn=1.

Disk-change latch:
- Set by any mount edge.
- Cleared by `dskchg_clr` on the selected drive.
- If a set and a clear hit the same drive in the same cycle, the set wins.

## Timing
- Reset values:
  - All FSMs OFF, counters 0.
  - present=0, sides=0, wprot=1, change latch=0.
  - READYn=1, sides=0, WPROTn=0, DSKCHGn=1, `spinning`=0.
- Outputs are registered: one cycle of latency from a `USEL` or state change to `READYn`/`sides`/`WPROTn`/`DSKCHGn`.
- Spin-up latency:
  - From `motor_run` rise to `READYn` fall is between (DELAY-1)·TICK_DIV+2 and DELAY·TICK_DIV+2 cycles, depending on prescaler phase.
  - The prescaler is never reset by motor events.
- Mount edge detect: the edge is registered 1 cycle after the strobe; media attributes are visible on the outputs 2 cycles after the strobe rises.
- Reset asserted mid-spin-up: all state returns to reset values immediately (asynchronous); no media survives reset.

## Configuration
- `FDD_DISKCHANGE_EN` defined: the change latches are implemented and `DSKCHGn` behaves as in Operation.
- `FDD_DISKCHANGE_EN` undefined:
  - Latches and `dskchg_clr` logic are removed.
  - `DSKCHGn` is constant 1.
  - `dskchg_clr` is ignored.

## Test plan
Bench parameters: TICK_DIV=10, DELAY=3, TIMEOUT=4.
- Reset, then mount drive 0 with size 737280 and readonly=0, `motor_run`=0 → sides=1, WPROTn=1, READYn=1, DSKCHGn=0.
- Raise `motor_run[0]` → `spinning[0]`=1 next cycle; READYn falls within 22..32 cycles.
- Drop motor for 15 cycles, then re-raise → READYn stays 0 throughout. Drop it for 45 cycles → READYn=1 and `spinning[0]`=0.
- Mount size 368640 with readonly=1 on drive 1 while drive 1 is in RUN → READYn=1 for at least 21 cycles, then 0; sides=0; WPROTn=0.
- Mount size 12345 on drive 2 → READYn stays 1 with the motor on. USEL=3 with DRIVES=3 → READYn=1, WPROTn=0.
- `dskchg_clr` on drive 0 in the same cycle as a mount strobe edge → DSKCHGn=0. `dskchg_clr` alone → DSKCHGn=1 after 1 cycle. With the macro undefined → DSKCHGn constantly 1.
